seg7_frame_reader: RTL and testbench



---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_pattern_decoder.sv | 37 +++
 rtl/seg7_frame_reader.sv | 135 +++++++++++++
 tb/tb_seg7_frame_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment-pattern constants and types for the seven-segment bus reader.
package seg7_pkg;

  typedef logic [7:0] seg7_t;
  typedef logic [3:0] digit_t;

  localparam int SEG_BIT_A  = 0;
  localparam int SEG_BIT_B  = 1;
  localparam int SEG_BIT_C  = 2;
  localparam int SEG_BIT_D  = 3;
  localparam int SEG_BIT_E  = 4;
  localparam int SEG_BIT_F  = 5;
  localparam int SEG_BIT_G  = 6;
  localparam int SEG_BIT_DP = 7;

  localparam seg7_t SEG_0     = 8'h3F;
  localparam seg7_t SEG_1     = 8'h06;
  localparam seg7_t SEG_2     = 8'h5B;
  localparam seg7_t SEG_3     = 8'h4F;
  localparam seg7_t SEG_4     = 8'h66;
  localparam seg7_t SEG_5     = 8'h6D;
  localparam seg7_t SEG_6     = 8'h7D;
  localparam seg7_t SEG_7     = 8'h07;
  localparam seg7_t SEG_8     = 8'h7F;
  localparam seg7_t SEG_9     = 8'h6F;
  localparam seg7_t SEG_A     = 8'h77;
  localparam seg7_t SEG_B     = 8'h7C;
  localparam seg7_t SEG_C     = 8'h39;
  localparam seg7_t SEG_D     = 8'h5E;
  localparam seg7_t SEG_E     = 8'h79;
  localparam seg7_t SEG_F     = 8'h71;
  localparam seg7_t SEG_BLANK = 8'h00;

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Segment pattern (a..g, dp excluded) back to a digit value plus an error flag.
// Hex letters A..F are recognised only when SEG7_HEX_DECODE_EN is defined.
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] seg_in,
  output digit_t     value,
  output logic       err
);

  always_comb begin
    value = 4'h0;
    err   = 1'b0;
    case ({1'b0, seg_in})
      SEG_0: value = 4'h0;
      SEG_1: value = 4'h1;
      SEG_2: value = 4'h2;
      SEG_3: value = 4'h3;
      SEG_4: value = 4'h4;
      SEG_5: value = 4'h5;
      SEG_6: value = 4'h6;
      SEG_7: value = 4'h7;
      SEG_8: value = 4'h8;
      SEG_9: value = 4'h9;
`ifdef SEG7_HEX_DECODE_EN
      SEG_A: value = 4'hA;
      SEG_B: value = 4'hB;
      SEG_C: value = 4'hC;
      SEG_D: value = 4'hD;
      SEG_E: value = 4'hE;
      SEG_F: value = 4'hF;
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_frame_reader.sv
// Recovers digit frames from a multiplexed seven-segment bus with valid/ready output.
// Optional SEG7_HEX_DECODE_EN (in seg7_pattern_decoder) adds A..F recognition.
module seg7_frame_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_en,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  input  logic [7:0]              seg_in,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    overrun
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_LOAD    = 1'b1;
  localparam logic [3:0] STABLE     = 4'(STABLE_CNT);

  logic [0:0]                        state_q, state_d;
  logic [NUM_DIGITS-1:0]             prev_sel_q, prev_sel_d;
  seg7_t                             prev_seg_q, prev_seg_d;
  logic [3:0]                        cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]             seen_q, seen_d;
  logic [NUM_DIGITS-1:0][3:0]        work_val_q, work_val_d;
  logic [NUM_DIGITS-1:0]             work_err_q, work_err_d;
  logic [NUM_DIGITS-1:0][3:0]        out_val_q, out_val_d;
  logic [NUM_DIGITS-1:0]             out_err_q, out_err_d;
  logic                              valid_q, valid_d;
  logic                              ovr_q, ovr_d;
  logic                              onehot, same, accept;
  digit_t                            dec_val;
  logic                              dec_err;

  // Decode what the previous-sample register will hold; on an accept that equals the current sample.
  seg7_pattern_decoder u_dec (
    .seg_in (prev_seg_d[6:0]),
    .value  (dec_val),
    .err    (dec_err)
  );

  always_comb begin
    onehot     = (digit_sel != '0) && ((digit_sel & (digit_sel - 1'b1)) == '0);
    same       = ({digit_sel, seg_in} == {prev_sel_q, prev_seg_q});
    prev_sel_d = prev_sel_q;
    prev_seg_d = prev_seg_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    if (sample_en) begin
      if (!onehot) begin
        cnt_d = 4'd0;
      end else if (same) begin
        if (cnt_q < STABLE) cnt_d = cnt_q + 4'd1;
        accept = (cnt_q == STABLE - 4'd1);
      end else begin
        prev_sel_d = digit_sel;
        prev_seg_d = seg_in;
        cnt_d      = 4'd1;
        accept     = (STABLE == 4'd1);
      end
    end

    seen_d     = seen_q;
    work_val_d = work_val_q;
    work_err_d = work_err_q;
    out_val_d  = out_val_q;
    out_err_d  = out_err_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    if (state_q == ST_LOAD) begin
      seen_d = '0;
      if (!valid_q || frame_ready) begin
        out_val_d = work_val_q;
        out_err_d = work_err_q;
        valid_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end

    // Accept lands after the frame clear so it starts the next frame.
    if (accept) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (prev_sel_d[i]) begin
          work_val_d[i] = dec_val;
          work_err_d[i] = dec_err;
          seen_d[i]     = 1'b1;
        end
      end
    end

    state_d = (&seen_d) ? ST_LOAD : ST_COLLECT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_COLLECT;
      prev_sel_q <= '0;
      prev_seg_q <= '0;
      cnt_q      <= '0;
      seen_q     <= '0;
      work_val_q <= '0;
      work_err_q <= '0;
      out_val_q  <= '0;
      out_err_q  <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_sel_q <= prev_sel_d;
      prev_seg_q <= prev_seg_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      work_val_q <= work_val_d;
      work_err_q <= work_err_d;
      out_val_q  <= out_val_d;
      out_err_q  <= out_err_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign frame_valid = valid_q;
  assign digits_out  = out_val_q;
  assign digit_err   = out_err_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_seg7_frame_reader.sv
// Randomized and directed checks of seg7_frame_reader against a run-length reference model.
module tb_seg7_frame_reader;

  localparam int N = 4;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           rst_n, sample_en, frame_ready;
  logic [N-1:0]   digit_sel;
  logic [7:0]     seg_in;
  logic           frame_valid, overrun;
  logic [4*N-1:0] digits_out;
  logic [N-1:0]   digit_err;

  seg7_frame_reader #(.NUM_DIGITS(N), .STABLE_CNT(S)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .digit_sel(digit_sel),
    .seg_in(seg_in), .frame_ready(frame_ready), .frame_valid(frame_valid),
    .digits_out(digits_out), .digit_err(digit_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: run length of identical samples, per-digit slots, held output frame.
  int         m_run;
  logic [N-1:0] m_psel;
  logic [7:0] m_pseg;
  bit         m_seen[N];
  int         m_wval[N];
  bit         m_werr[N];
  int         m_oval[N];
  bit         m_oerr[N];
  bit         m_fv, m_ov;
  logic       rdy;

  function automatic int ref_dec(input logic [6:0] p);
    case (p)
      7'h3F: return 0;  7'h06: return 1;  7'h5B: return 2;  7'h4F: return 3;
      7'h66: return 4;  7'h6D: return 5;  7'h7D: return 6;  7'h07: return 7;
      7'h7F: return 8;  7'h6F: return 9;
`ifdef SEG7_HEX_DECODE_EN
      7'h77: return 10; 7'h7C: return 11; 7'h39: return 12;
      7'h5E: return 13; 7'h79: return 14; 7'h71: return 15;
`endif
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_psel = '0; m_pseg = '0; m_fv = 0; m_ov = 0;
    for (int i = 0; i < N; i++) begin
      m_seen[i] = 0; m_wval[i] = 0; m_werr[i] = 0; m_oval[i] = 0; m_oerr[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit complete;
    int idx, d;
    if (!rst_n) begin model_reset(); return; end
    complete = 1;
    for (int i = 0; i < N; i++) if (!m_seen[i]) complete = 0;
    if (complete) begin
      if (!m_fv || frame_ready) begin
        for (int i = 0; i < N; i++) begin m_oval[i] = m_wval[i]; m_oerr[i] = m_werr[i]; end
        m_fv = 1;
      end else m_ov = 1;
      for (int i = 0; i < N; i++) m_seen[i] = 0;
    end else if (m_fv && frame_ready) m_fv = 0;
    if (sample_en) begin
      if ($countones(digit_sel) != 1) m_run = 0;
      else begin
        if (digit_sel == m_psel && seg_in == m_pseg) m_run++;
        else begin m_psel = digit_sel; m_pseg = seg_in; m_run = 1; end
        if (m_run == S) begin
          idx = 0;
          for (int i = 0; i < N; i++) if (digit_sel[i]) idx = i;
          d = ref_dec(seg_in[6:0]);
          m_wval[idx] = (d < 0) ? 0 : d;
          m_werr[idx] = (d < 0);
          m_seen[idx] = 1;
        end
      end
    end
  endtask

  task automatic compare();
    logic [4*N-1:0] ev;
    logic [N-1:0]   ee;
    for (int i = 0; i < N; i++) begin
      ev[4*i +: 4] = m_oval[i][3:0];
      ee[i]        = m_oerr[i];
    end
    chk("frame_valid", {31'd0, frame_valid}, {31'd0, m_fv});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ov});
    chk("digits_out", {16'd0, digits_out}, {16'd0, ev});
    chk("digit_err", {28'd0, digit_err}, {28'd0, ee});
  endtask

  task automatic step(input logic en, input logic [N-1:0] sel, input logic [7:0] seg);
    sample_en = en; digit_sel = sel; seg_in = seg; frame_ready = rdy;
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic show(input int dig, input logic [7:0] pat, input int n);
    logic [N-1:0] sel;
    sel = '0;
    sel[dig] = 1'b1;
    for (int k = 0; k < n; k++) begin
      step(1'b1, sel, pat);
      step(1'b0, sel, pat);
    end
  endtask

  logic [7:0] pats[12];

  initial begin
    pats = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F, 8'h77, 8'h00};
    rst_n = 1'b0; rdy = 1'b0;
    model_reset();
    #1;
    step(1'b0, '0, 8'h00);
    step(1'b0, '0, 8'h00);
    chk("reset_valid", {31'd0, frame_valid}, 32'd0);
    rst_n = 1'b1;

    // Basic frame 4321
    show(0, 8'h06, 3); show(1, 8'h5B, 3); show(2, 8'h4F, 3); show(3, 8'h66, 3);
    chk("t1_valid", {31'd0, frame_valid}, 32'd1);
    chk("t1_digits", {16'd0, digits_out}, 32'h4321);
    chk("t1_err", {28'd0, digit_err}, 32'd0);
    rdy = 1'b1; step(1'b0, '0, 8'h00); rdy = 1'b0;
    chk("t1_drop", {31'd0, frame_valid}, 32'd0);

    // Blank pattern flags an error
    show(0, 8'h3F, 3); show(1, 8'h3F, 3); show(2, 8'h00, 3); show(3, 8'h3F, 3);
    chk("t2_digits", {16'd0, digits_out}, 32'h0000);
    chk("t2_err", {28'd0, digit_err}, 32'h4);
    rdy = 1'b1; step(1'b0, '0, 8'h00); rdy = 1'b0;

    // Unstable digit never accepted, then held
    for (int k = 0; k < 6; k++) show(0, (k % 2) ? 8'h07 : 8'h06, 1);
    chk("t3_novalid", {31'd0, frame_valid}, 32'd0);
    show(0, 8'h07, 3); show(1, 8'h3F, 3); show(2, 8'h3F, 3); show(3, 8'h3F, 3);
    chk("t3_digits", {16'd0, digits_out}, 32'h0007);
    rdy = 1'b1; step(1'b0, '0, 8'h00); rdy = 1'b0;

    // Overrun: second frame dropped while first is held
    show(0, 8'h06, 3); show(1, 8'h5B, 3); show(2, 8'h4F, 3); show(3, 8'h66, 3);
    show(0, 8'h7F, 3); show(1, 8'h7F, 3); show(2, 8'h7F, 3); show(3, 8'h7F, 3);
    chk("t4_overrun", {31'd0, overrun}, 32'd1);
    chk("t4_held", {16'd0, digits_out}, 32'h4321);
    rdy = 1'b1; step(1'b0, '0, 8'h00); rdy = 1'b0;
    chk("t4_drop", {31'd0, frame_valid}, 32'd0);

    // Non-one-hot select restarts the stability count
    show(0, 8'h3F, 3); show(2, 8'h3F, 3); show(3, 8'h3F, 3);
    show(1, 8'h6D, 2);
    step(1'b1, 4'b0011, 8'h6D); step(1'b0, '0, 8'h6D);
    show(1, 8'h6D, 2);
    chk("t5_wait", {31'd0, frame_valid}, 32'd0);
    show(1, 8'h6D, 1);
    chk("t5_valid", {31'd0, frame_valid}, 32'd1);
    chk("t5_digits", {16'd0, digits_out}, 32'h0050);
    rdy = 1'b1; step(1'b0, '0, 8'h00); rdy = 1'b0;

    // Hex F on digit 3
    show(0, 8'h3F, 3); show(1, 8'h3F, 3); show(2, 8'h3F, 3); show(3, 8'h71, 3);
`ifdef SEG7_HEX_DECODE_EN
    chk("t6_digits", {16'd0, digits_out}, 32'hF000);
    chk("t6_err", {28'd0, digit_err}, 32'h0);
`else
    chk("t6_digits", {16'd0, digits_out}, 32'h0000);
    chk("t6_err", {28'd0, digit_err}, 32'h8);
`endif
    rdy = 1'b1; step(1'b0, '0, 8'h00); rdy = 1'b0;

    // Randomized runs
    for (int it = 0; it < 400; it++) begin
      logic [N-1:0] sel;
      logic [7:0]   seg;
      int           reps;
      sel = '0;
      sel[$urandom_range(0, N-1)] = 1'b1;
      if ($urandom_range(0, 9) == 0) sel = 4'(($urandom_range(0, 15)));
      seg = ($urandom_range(0, 7) == 0) ? 8'($urandom()) : pats[$urandom_range(0, 11)];
      if ($urandom_range(0, 5) == 0) seg[7] = 1'b1;
      reps = $urandom_range(1, 4);
      rdy = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < reps; k++) begin
        step(1'b1, sel, seg);
        if ($urandom_range(0, 1) == 1) step(1'b0, sel, seg);
      end
    end

    // Reset with a held frame and a partial frame in progress
    rdy = 1'b0;
    step(1'b0, '0, 8'h00); step(1'b0, '0, 8'h00);
    show(0, 8'h06, 3); show(1, 8'h06, 3); show(2, 8'h06, 3); show(3, 8'h06, 3);
    show(0, 8'h5B, 2);
    rst_n = 1'b0;
    step(1'b1, 4'b0001, 8'h5B);
    chk("rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_digits", {16'd0, digits_out}, 32'd0);
    chk("rst_err", {28'd0, digit_err}, 32'd0);
    rst_n = 1'b1;
    show(0, 8'h5B, 1);
    step(1'b0, '0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
